// File: rtl/disp_scan4_pkg.sv
// Shared constants for the display blocks: scan slot encodings, glyph table
// and the all-off segment pattern.
package disp_scan4_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}; 7 drawn without f, 9 drawn without d.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0011000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        return GLYPH_TABLE[nib];
    endfunction

    function automatic scan_state_e next_slot(input scan_state_e cur);
        scan_state_e nxt;
        case (cur)
            S0:      nxt = S1;
            S1:      nxt = S2;
            S2:      nxt = S3;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex7seg
    import disp_scan4_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = hex_glyph(hex_i);
    end

endmodule

// File: rtl/disp_scan4.sv
// Four-digit multiplexed display scanner: shifts loaded nibbles into a
// four-deep history and time-multiplexes them onto active-low seg/an/dp.
module disp_scan4
    import disp_scan4_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] value_in,
    input  logic       load,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    logic [3:0]  hist_q [4];
    logic [3:0]  hist_d [4];
    logic [3:0]  vld_q, vld_d;

    scan_state_e state_q;
    logic [1:0]  slot_idx;

    logic [3:0]  sel_digit;
    logic        slot_on;
    logic [6:0]  glyph;

    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        dp_q, dp_d;

    // Refresh divider: tick marks the cycle on which the counter wraps.
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // History shift register; every load is captured regardless of scan rate.
    always_comb begin
        hist_d = hist_q;
        vld_d  = vld_q;
        if (load) begin
            hist_d[0] = value_in;
            for (int k = 1; k < 4; k++) begin
                hist_d[k] = hist_q[k-1];
            end
            vld_d = {vld_q[2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                hist_q[k] <= '0;
            end
            vld_q <= '0;
        end else begin
            hist_q <= hist_d;
            vld_q  <= vld_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S0;
        end else if (tick) begin
            state_q <= next_slot(state_q);
        end
    end

    // Slot mux feeds the single shared decoder.
    always_comb begin
        slot_idx  = state_q;
        sel_digit = hist_q[slot_idx];
        slot_on   = vld_q[slot_idx] & ~blank;
    end

    hex7seg u_hex7seg (
        .hex_i (sel_digit),
        .seg_o (glyph)
    );

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        dp_d  = 1'b1;
        if (slot_on) begin
            seg_d = glyph;
            an_d  = ~(4'b0001 << slot_idx);
            dp_d  = (state_q != S0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= SEG_BLANK;
            an_q  <= AN_OFF;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_disp_scan4.sv
// Directed bench for disp_scan4 with REFRESH_DIV=4; observed value is {an,seg,dp}.
module tb_disp_scan4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] value_in;
    logic       load;
    logic       blank;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int cyc;
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [11:0] ALL_OFF = 12'hFFF;

    disp_scan4 #(.REFRESH_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .load     (load),
        .blank    (blank),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: {an,seg,dp} got %b_%b_%b expected %b_%b_%b",
                     tag, cyc, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    function automatic logic [11:0] obs();
        return {an, seg, dp};
    endfunction

    // Output after edge n shows the slot the FSM held before that edge.
    function automatic int slot_of(input int n);
        return ((n - 1) / 4) % 4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        blank = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic load_seq(input logic [3:0] v0, input logic [3:0] v1,
                            input logic [3:0] v2, input logic [3:0] v3);
        logic [3:0] vals [4];
        vals = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) begin
            load     = 1'b1;
            value_in = vals[i];
            step();
        end
        load = 1'b0;
    endtask

    logic [11:0] exp_tab [4];

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        blank    = 1'b0;
        value_in = 4'd0;
        cyc      = 0;
        #1;
        chk("reset_outputs", obs(), ALL_OFF);

        // Idle after reset: nothing is valid, display stays dark.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step();
            chk("idle_dark", obs(), ALL_OFF);
        end

        // Single load of 3 lights only digit 0 with dp.
        do_reset();
        load     = 1'b1;
        value_in = 4'd3;
        step();
        load = 1'b0;
        chk("single_first", obs(), ALL_OFF);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("single_scan", obs(),
                (slot_of(cyc) == 0) ? {4'b1110, 7'b0110000, 1'b0} : ALL_OFF);
        end

        // Five back-to-back loads: 1 is pushed out, 2..5 remain.
        do_reset();
        load_seq(4'd1, 4'd2, 4'd3, 4'd4);
        load     = 1'b1;
        value_in = 4'd5;
        step();
        load = 1'b0;
        exp_tab[0] = {4'b1110, 7'b0010010, 1'b0};
        exp_tab[1] = {4'b1101, 7'b0011001, 1'b1};
        exp_tab[2] = {4'b1011, 7'b0110000, 1'b1};
        exp_tab[3] = {4'b0111, 7'b0100100, 1'b1};
        for (int i = 0; i < 19; i++) begin
            step();
            chk("burst_scan", obs(), exp_tab[slot_of(cyc)]);
        end

        // Load of 5 on the tick edge that enters S0.
        do_reset();
        for (int i = 0; i < 15; i++) step();
        load     = 1'b1;
        value_in = 4'd5;
        step();
        load = 1'b0;
        chk("tickload_prev", obs(), ALL_OFF);
        step();
        chk("tickload_s0", obs(), {4'b1110, 7'b0010010, 1'b0});

        // Blanking with four valid digits (7,9,E,F), then resume mid-rotation.
        do_reset();
        load_seq(4'h7, 4'h9, 4'hE, 4'hF);
        blank = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("blank_dark", obs(), ALL_OFF);
        end
        blank = 1'b0;
        exp_tab[0] = {4'b1110, 7'b0001110, 1'b0};
        exp_tab[1] = {4'b1101, 7'b0000110, 1'b1};
        exp_tab[2] = {4'b1011, 7'b0011000, 1'b1};
        exp_tab[3] = {4'b0111, 7'b1111000, 1'b1};
        step();
        chk("blank_resume_slot1", obs(), exp_tab[1]);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("blank_resume_scan", obs(), exp_tab[slot_of(cyc)]);
        end

        // Asynchronous reset while showing S2, then a fresh load of 0.
        do_reset();
        load_seq(4'd3, 4'd2, 4'd1, 4'd0);
        for (int i = 0; i < 5; i++) step();
        chk("pre_reset_s2", obs(), {4'b1011, 7'b0100100, 1'b1});
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset", obs(), ALL_OFF);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        cyc      = 0;
        load     = 1'b1;
        value_in = 4'd0;
        step();
        load = 1'b0;
        chk("post_reset_first", obs(), ALL_OFF);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("post_reset_scan", obs(),
                (slot_of(cyc) == 0) ? {4'b1110, 7'b1000000, 1'b0} : ALL_OFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
